// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered, handshaked ALU-control decoder with optional RV32M multi-cycle hold-off.
//   Config macro: ALU_SEQ_MEXT_EN enables M-extension decode (codes 11..18) and the EXEC wait state.
//   Ports: clk, rst_n (sync, active-low), flush (sync)
//          in_valid/in_ready      : decode request handshake
//          alu_op, opcode_5, funct3, funct7_5, funct7_0 : instruction fields to decode
//          out_valid/out_ready    : result handshake, alu_ctrl/multi_cycle stable while out_valid
//          alu_ctrl [CTRL_W]      : ALU operation code
//          multi_cycle            : registered op is an M-op
//          busy                   : M-op still executing (issue must stall)
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 33,
    parameter int CTRL_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic              opcode_5,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              funct7_0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              multi_cycle,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    localparam logic [4:0] C_ADD = 5'd0, C_SUB = 5'd1, C_AND = 5'd2, C_OR = 5'd3,
                           C_XOR = 5'd4, C_SLL = 5'd5, C_SRL = 5'd6, C_SRA = 5'd7,
                           C_SLT = 5'd8, C_SLTU = 5'd9, C_PASSB = 5'd10, C_MUL = 5'd11,
                           C_DIV = 5'd15;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic              mc_q, mc_d;
    logic              m_sel, accept;
    logic [4:0]        base_code, dec_code;
    logic              dec_mc;
    logic [7:0]        dec_lat;

    always_comb begin
        m_sel = 1'b0;
`ifdef ALU_SEQ_MEXT_EN
        m_sel = opcode_5 && funct7_0;
`endif
        case (funct3)
            3'b000:  base_code = (opcode_5 && funct7_5) ? C_SUB : C_ADD;
            3'b001:  base_code = C_SLL;
            3'b010:  base_code = C_SLT;
            3'b011:  base_code = C_SLTU;
            3'b100:  base_code = C_XOR;
            3'b101:  base_code = funct7_5 ? C_SRA : C_SRL;
            3'b110:  base_code = C_OR;
            default: base_code = C_AND;
        endcase
        dec_code = alu_op == 2'b00 ? C_ADD :
                   alu_op == 2'b01 ? C_SUB :
                   alu_op == 2'b11 ? C_PASSB :
                   m_sel           ? C_MUL + {2'b00, funct3} : base_code;
        dec_mc   = dec_code >= C_MUL;
        // Without the M-extension dec_code never reaches C_MUL, so the latency is always 1.
        dec_lat  = dec_code >= C_DIV ? 8'(DIV_CYCLES) : dec_code >= C_MUL ? 8'(MUL_CYCLES) : 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_ctrl_q <= '0;
            mc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_ctrl_q <= alu_ctrl_d;
            mc_q       <= mc_d;
        end
    end

    always_comb begin
        accept     = in_valid && in_ready && !flush;
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_ctrl_d = alu_ctrl_q;
        mc_d       = mc_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            // Covers both IDLE issue and back-to-back issue out of HOLD.
            alu_ctrl_d = CTRL_W'(dec_code);
            mc_d       = dec_mc;
            state_d    = dec_lat == 8'd1 ? HOLD : EXEC;
            cnt_d      = dec_lat - 8'd1;
        end else if (state_q == EXEC) begin
            cnt_d   = cnt_q - 8'd1;
            state_d = cnt_q == 8'd1 ? HOLD : EXEC;
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
        out_valid = state_q == HOLD;
        alu_ctrl  = alu_ctrl_q;
`ifdef ALU_SEQ_MEXT_EN
        busy        = state_q == EXEC;
        multi_cycle = mc_q;
`else
        busy        = 1'b0;
        multi_cycle = 1'b0;
`endif
    end

`ifndef ALU_SEQ_MEXT_EN
    logic unused_sig;
    assign unused_sig = mc_q ^ funct7_0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer; timestamp reference model plus queued expected results.
//   Honours ALU_SEQ_MEXT_EN the same way as the design build.
module tb_alu_op_sequencer;
    localparam int MUL = 3;
    localparam int DIV = 33;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0] alu_op = 2'b00;
    logic       opcode_5 = 1'b0, funct7_5 = 1'b0, funct7_0 = 1'b0;
    logic [2:0] funct3 = 3'b000;
    logic       in_ready, out_valid, multi_cycle, busy;
    logic [4:0] alu_ctrl;

    alu_op_sequencer #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV), .CTRL_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .opcode_5(opcode_5), .funct3(funct3), .funct7_5(funct7_5),
        .funct7_0(funct7_0), .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .multi_cycle(multi_cycle), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef ALU_SEQ_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    typedef struct {int code; bit mc;} exp_t;
    exp_t sb[$];

    // Reference model: one outstanding op, described by when its result becomes visible.
    bit have_op = 1'b0;
    int rdy_cyc = 0;
    int cyc = 0;
    int last_code = 0;
    bit last_mc = 1'b0;
    bit mon_en = 1'b0;
    int total = 0;
    int passed = 0;

    function automatic int ref_code(logic [1:0] op, logic o5, logic [2:0] f3, logic f75, logic f70);
        int base[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        int r;
        if (op == 2'b00) return 0;
        if (op == 2'b01) return 1;
        if (op == 2'b11) return 10;
        if (MEXT && o5 && f70) return 11 + int'(f3);
        r = base[f3];
        if (f3 == 3'd0 && o5 && f75) r = 1;
        if (f3 == 3'd5 && f75) r = 7;
        return r;
    endfunction

    function automatic int ref_lat(int code);
        return code >= 15 ? DIV : code >= 11 ? MUL : 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic o5, input logic [2:0] f3,
                        input logic f75, input logic f70, input logic ordy, input logic fl, input logic rn);
        bit exp_ov, exp_ir, acc;
        int code;
        exp_ov = have_op && cyc >= rdy_cyc;
        if (!rn || (fl && exp_ov)) ordy = 1'b0;
        exp_ir = !have_op || (exp_ov && ordy);
        acc = rn && !fl && v && exp_ir;
        code = ref_code(op, o5, f3, f75, f70);
        in_valid = v; alu_op = op; opcode_5 = o5; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
        out_ready = ordy; flush = fl; rst_n = rn;
        if (acc) sb.push_back('{code, code >= 11});
        @(posedge clk);
        if (!rn) begin
            have_op = 1'b0; sb.delete(); last_code = 0; last_mc = 1'b0;
        end else if (fl) begin
            if (have_op && sb.size() > 0) void'(sb.pop_back());
            have_op = 1'b0;
        end else begin
            if (exp_ov && ordy) have_op = 1'b0;
            if (acc) begin
                have_op = 1'b1; rdy_cyc = cyc + 1 + ref_lat(code) - 1;
                last_code = code; last_mc = code >= 11;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, ordy, 1'b0, 1'b1);
    endtask

    // Monitor: checks timing flags every cycle and pops the scoreboard on each output handshake.
    initial begin
        exp_t e;
        bit ov;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ov = have_op && cyc >= rdy_cyc;
                chk("out_valid", int'(out_valid), int'(ov));
                chk("busy", int'(busy), int'(MEXT && have_op && cyc < rdy_cyc));
                chk("in_ready", int'(in_ready), int'(!have_op || (ov && out_ready)));
                chk("alu_ctrl_held", int'(alu_ctrl), last_code);
                chk("multi_cycle_held", int'(multi_cycle), int'(MEXT && last_mc));
                if (out_valid && out_ready && rst_n && !flush) begin
                    if (sb.size() == 0) chk("unexpected_output", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("sb_code", int'(alu_ctrl), e.code);
                        chk("sb_multi_cycle", int'(multi_cycle), int'(MEXT && e.mc));
                    end
                end
            end
        end
    end

    initial begin
        #1;
        // Reset held two cycles with in_valid high.
        step(1'b1, 2'b10, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b1, 2'b10, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        // Base decode: SUB, ADD, SRA, issued back-to-back.
        step(1'b1, 2'b10, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        // DIV (M-op with MEXT, XOR without).
        step(1'b1, 2'b10, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(DIV + 2, 1'b1);
        // Backpressure for 5 cycles, then back-to-back PASSB.
        step(1'b1, 2'b10, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b0);
        step(1'b1, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(2, 1'b1);
        // Flush one cycle after issuing MUL; in_valid during flush is ignored.
        step(1'b1, 2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1);
        // funct7_0 with funct3=000 and funct7_5=0: ADD without MEXT, MUL with it.
        step(1'b1, 2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(MUL + 2, 1'b1);
        // Reset in the middle of an op.
        step(1'b1, 2'b10, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            step(1'($urandom_range(0, 3) != 0), op, 1'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 99) != 0));
        end
        idle(DIV + 4, 1'b1);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Registered, handshaked successor to the combinational ALU-control decoder in the control unit (cu).
- Decodes alu_op, funct3, funct7 and opcode bit 5 into a 5-bit ALU control code.
- Adds the RV32M multiply/divide encodings.
- Holds off the issue stage for a parametrised number of cycles while multi-cycle M-ops execute, so hazard logic can stall on a single busy flag.

Parameters:
- MUL_CYCLES, 3, cycles from accept to out_valid for MUL/MULH/MULHSU/MULHU (legal range 1..255).
- DIV_CYCLES, 33, cycles from accept to out_valid for DIV/DIVU/REM/REMU (legal range 1..255).
- CTRL_W, 5, alu_ctrl width (must be ≥5).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  decode request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- alu_op  in  2  00 add, 01 branch-sub, 10 funct-decoded, 11 pass-B (LUI).
- opcode_5  in  1  instruction bit 5 (1 = R-type).
- funct3  in  3  instruction bits 14:12.
- funct7_5  in  1  instruction bit 30.
- funct7_0  in  1  instruction bit 25 (M-extension select).
- out_valid  out  1  alu_ctrl valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- alu_ctrl  out  CTRL_W  ALU operation code.
- multi_cycle  out  1  registered op is an M-op.
- busy  out  1  high while in EXEC.

Behaviour:
Codes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB.
- 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU.
- Codes 19 and up are never produced.

Decode:
- alu_op=00 → ADD; 01 → SUB; 11 → PASSB.
- alu_op=10 with opcode_5 && funct7_0 → M-op: funct3 0..7 maps to codes 11..18 in order.
- Otherwise alu_op=10, by funct3:
  - 000 → SUB if opcode_5 && funct7_5, else ADD.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
  - 101 → SRA if funct7_5, else SRL (independent of opcode_5).
  - 110 OR; 111 AND.

FSM states: IDLE, EXEC, HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). Combinational; does not depend on in_valid.
- On accept: alu_ctrl and multi_cycle are registered.
  - Latency LAT = 1 for base ops, MUL_CYCLES for codes 11-14, DIV_CYCLES for codes 15-18.
  - If LAT==1 → HOLD; else → EXEC with counter = LAT-1.
- EXEC: counter decrements each cycle; when counter==1 → HOLD next edge. out_valid=0, in_ready=0.
- HOLD: out_valid=1. alu_ctrl and multi_cycle stay stable until the handshake.
  - out_ready && accept → back-to-back issue: new op registered, same transitions as from IDLE.
  - out_ready without accept → IDLE.
  - !out_ready → stay in HOLD.
- Result: accept at edge N gives out_valid high after edge N+LAT-1, i.e. visible in cycle N+LAT.
- out_valid, busy and multi_cycle are registered (derived from state and registers only).

Priority and boundary conditions:
- Priority order: rst_n low > flush > handshake.
- Reset (rst_n low at an edge): state IDLE, counter 0, alu_ctrl 0, multi_cycle 0, out_valid 0, busy 0. Reset mid-EXEC aborts immediately.
- flush: next state IDLE, out_valid 0, counter 0, alu_ctrl held. in_valid in the same cycle is ignored (in_ready is still driven per the formula; the bench must not count that as an accept).
- Counter width is 8 bits; no wrap-around is possible within the legal parameter range.

Optional Feature:
- ALU_SEQ_MEXT_EN defined: M-extension decode and EXEC state as described above.
- Not defined:
  - funct7_0 is ignored and falls through to base decode (funct3 000 with funct7_0=1 gives ADD).
  - Codes 11-18 are never produced; EXEC is unreachable.
  - busy and multi_cycle are tied 0; MUL_CYCLES and DIV_CYCLES are unused.
  - All ports are retained.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, alu_ctrl=0, busy=0, in_ready=1 after release.
- Base decode: alu_op=10, opcode_5=1, funct7_5=1, funct3=000 → alu_ctrl=1 (SUB), out_valid one cycle after accept. Same with opcode_5=0 → 0 (ADD). funct3=101, funct7_5=1, opcode_5=0 → 7 (SRA).
- Multi-cycle: MEXT_EN, DIV_CYCLES=33, alu_op=10, opcode_5=1, funct7_0=1, funct3=100:
  - busy=1 for 32 cycles, in_ready=0 throughout.
  - out_valid rises 33 cycles after accept with alu_ctrl=15, multi_cycle=1.
- Backpressure and back-to-back:
  - out_ready=0 for 5 cycles → alu_ctrl stable.
  - Then out_ready=1 with new in_valid (alu_op=11) in the same cycle → next cycle alu_ctrl=10, out_valid=1, no bubble.
- Flush: flush=1 mid-EXEC of MUL (MUL_CYCLES=3, cycle 2) → next cycle state IDLE, busy=0, out_valid=0; in_valid in the flush cycle is not accepted.
- Macro off: funct7_0=1, funct3=000, opcode_5=1, funct7_5=0 → alu_ctrl=0, latency 1, busy never asserted.
